// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem read, IF/ID register with a one-entry skid buffer.
// Optional misaligned-PC marker generation is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        flush,
  input  logic        id_stall,
  output logic        fetch_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_misaligned
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  entry_t      if_id_q, if_id_d;
  logic        skid_valid_q, skid_valid_d;
  entry_t      skid_q, skid_d;

  logic   misalign;
  logic   handshake;
  logic   resp_deliver;
  logic   deliver;
  logic   to_ifid;
  logic   to_skid;
  entry_t dlv;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = (state_q == S_REQ) && (pc_in[1:0] != 2'b00) && !flush && !skid_valid_q;
`else
  assign misalign = 1'b0;
`endif

  // A full skid blocks new requests, so a skid entry and a delivery never collide.
  assign imem_req_valid = !reset && (state_q == S_REQ) && !flush && !skid_valid_q && !misalign;
  assign imem_req_addr  = {pc_in[31:2], 2'b00};
  assign handshake      = imem_req_valid && imem_req_ready;
  assign fetch_stall    = !reset && !flush && !handshake && !misalign;

  assign resp_deliver = (state_q == S_WAIT) && imem_resp_valid && !flush;
  assign deliver      = resp_deliver || misalign;
  assign dlv          = misalign ? '{pc: pc_in, instr: 32'h0000_0013, mis: 1'b1}
                                 : '{pc: pending_pc_q, instr: imem_resp_data, mis: 1'b0};
  assign to_ifid      = deliver && (!if_id_valid_q || !id_stall);
  assign to_skid      = deliver && !to_ifid;

  always_comb begin
    state_d      = state_q;
    pending_pc_d = pending_pc_q;
    case (state_q)
      S_REQ: begin
        if (handshake) begin
          state_d      = S_WAIT;
          pending_pc_d = pc_in;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) state_d = S_REQ;
        else if (flush)      state_d = S_DROP;
      end
      S_DROP: begin
        if (imem_resp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    if_id_valid_d = if_id_valid_q;
    if_id_d       = if_id_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    if (flush) begin
      if_id_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
    end else begin
      if (!id_stall) begin
        if (skid_valid_q) begin
          if_id_valid_d = 1'b1;
          if_id_d       = skid_q;
          skid_valid_d  = 1'b0;
        end else if (deliver) begin
          if_id_valid_d = 1'b1;
          if_id_d       = dlv;
        end else begin
          if_id_valid_d = 1'b0;
        end
      end else if (to_ifid) begin
        if_id_valid_d = 1'b1;
        if_id_d       = dlv;
      end
      if (to_skid) begin
        skid_valid_d = 1'b1;
        skid_d       = dlv;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_REQ;
      pending_pc_q  <= '0;
      if_id_valid_q <= 1'b0;
      if_id_q       <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
    end else begin
      state_q       <= state_d;
      pending_pc_q  <= pending_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_q       <= if_id_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
    end
  end

  assign if_id_valid      = if_id_valid_q;
  assign if_id_pc         = if_id_q.pc;
  assign if_id_instr      = if_id_q.instr;
  assign if_id_misaligned = if_id_q.mis;

endmodule
